alu_req_arbiter: RTL and testbench

- Parametrised multi-channel front end for the ALU input/output interfaces.
- Buffers ALU operation requests from CHANNELS independent sources in per-channel FIFOs and arbitrates them round-robin onto the single ALU input port (ACT/OP/MOVI/operands, gated by ALU_RDY).
- Tracks issued requests in an in-order tag FIFO, so each EX_ALU result returns tagged with its originating channel.

---
 rtl/alu_req_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Multi-channel request front end for the ALU: per-channel FIFOs, round-robin issue, in-order result tagging.
// Optional issue/stall statistics counters are compiled in when ALU_ARB_STATS_EN is defined.
module alu_req_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_DEPTH  = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [CHANNELS-1:0]            IN_ACT,
  output logic [CHANNELS-1:0]            IN_RDY,
  input  logic [4*CHANNELS-1:0]          IN_OP,
  input  logic [2*CHANNELS-1:0]          IN_MOVI,
  input  logic [DATA_WIDTH*CHANNELS-1:0] IN_REG_A,
  input  logic [DATA_WIDTH*CHANNELS-1:0] IN_REG_B,
  input  logic [DATA_WIDTH*CHANNELS-1:0] IN_IMM,
  input  logic [DATA_WIDTH*CHANNELS-1:0] IN_MEM,
  input  logic                           ALU_RDY,
  output logic                           ACT,
  output logic [3:0]                     OP,
  output logic [1:0]                     MOVI,
  output logic [DATA_WIDTH-1:0]          REG_A,
  output logic [DATA_WIDTH-1:0]          REG_B,
  output logic [DATA_WIDTH-1:0]          IMM,
  output logic [DATA_WIDTH-1:0]          MEM,
  input  logic [DATA_WIDTH-1:0]          EX_ALU,
  input  logic                           EX_ALU_VLD,
  output logic                           RES_VLD,
  output logic [CH_W-1:0]                RES_CH,
  output logic [DATA_WIDTH-1:0]          RES_DATA,
  output logic                           ERR
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]                    ISSUE_CNT,
  output logic [31:0]                    STALL_CNT
`endif
);

  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TAG_DEPTH);

  typedef struct packed {
    logic [3:0]            op;
    logic [1:0]            movi;
    logic [DATA_WIDTH-1:0] reg_a;
    logic [DATA_WIDTH-1:0] reg_b;
    logic [DATA_WIDTH-1:0] imm;
    logic [DATA_WIDTH-1:0] mem;
  } req_t;

  req_t          fifo_mem_r [CHANNELS][FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_r   [CHANNELS];
  logic [FW-1:0] rd_ptr_r   [CHANNELS];
  logic [FW:0]   cnt_r      [CHANNELS];
  req_t          in_req_s   [CHANNELS];

  logic [CHANNELS-1:0] wr_en_s, pop_en_s, nonempty_s, in_rdy_s;
  logic [CH_W-1:0]     rr_r, grant_s, rr_next_s;
  logic                found_s, take_s, act_s;
  int                  idx_s;
  req_t                head_s, last_r, out_req_s;

  logic [CH_W-1:0] tag_mem_r [TAG_DEPTH];
  logic [TW-1:0]   tag_wr_r, tag_rd_r;
  logic [TW:0]     tag_cnt_r;
  logic            tag_full_s, tag_empty_s, res_pop_s;

  logic                  res_vld_r, err_r;
  logic [CH_W-1:0]       res_ch_r;
  logic [DATA_WIDTH-1:0] res_data_r;

  // Unpack channel inputs and derive per-channel FIFO status
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      in_req_s[c].op    = IN_OP[4*c +: 4];
      in_req_s[c].movi  = IN_MOVI[2*c +: 2];
      in_req_s[c].reg_a = IN_REG_A[DATA_WIDTH*c +: DATA_WIDTH];
      in_req_s[c].reg_b = IN_REG_B[DATA_WIDTH*c +: DATA_WIDTH];
      in_req_s[c].imm   = IN_IMM[DATA_WIDTH*c +: DATA_WIDTH];
      in_req_s[c].mem   = IN_MEM[DATA_WIDTH*c +: DATA_WIDTH];
      nonempty_s[c]     = (cnt_r[c] != '0);
      in_rdy_s[c]       = RST & (cnt_r[c] != (FW+1)'(FIFO_DEPTH));
      wr_en_s[c]        = IN_ACT[c] & in_rdy_s[c];
    end
  end

  // Round-robin search starting at the pointer, plus issue qualification
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx_s   = (int'(rr_r) + i >= CHANNELS) ? int'(rr_r) + i - CHANNELS : int'(rr_r) + i;
      take_s  = ~found_s & nonempty_s[idx_s];
      grant_s = take_s ? CH_W'(idx_s) : grant_s;
      found_s = found_s | nonempty_s[idx_s];
    end
    act_s     = found_s & ALU_RDY & ~tag_full_s;
    rr_next_s = (grant_s == CH_W'(CHANNELS - 1)) ? '0 : grant_s + CH_W'(1);
    head_s    = fifo_mem_r[grant_s][rd_ptr_r[grant_s]];
    out_req_s = act_s ? head_s : last_r;
  end

  // Pop strobe for the granted channel
  always_comb begin
    pop_en_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pop_en_s[c] = act_s & (grant_s == CH_W'(c));
    end
  end

  // Per-channel request FIFOs; simultaneous write and pop leave the count unchanged
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int e = 0; e < FIFO_DEPTH; e++) fifo_mem_r[c][e] <= '0;
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        cnt_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en_s[c]) begin
          fifo_mem_r[c][wr_ptr_r[c]] <= in_req_s[c];
          wr_ptr_r[c]                <= wr_ptr_r[c] + FW'(1);
        end
        if (pop_en_s[c]) rd_ptr_r[c] <= rd_ptr_r[c] + FW'(1);
        case ({wr_en_s[c], pop_en_s[c]})
          2'b10:   cnt_r[c] <= cnt_r[c] + (FW+1)'(1);
          2'b01:   cnt_r[c] <= cnt_r[c] - (FW+1)'(1);
          default: cnt_r[c] <= cnt_r[c];
        endcase
      end
    end
  end

  // Round-robin pointer and last-issued fields, which the ALU port shows while idle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rr_r   <= '0;
      last_r <= '0;
    end else if (act_s) begin
      rr_r   <= rr_next_s;
      last_r <= head_s;
    end
  end

  assign tag_full_s  = (tag_cnt_r == (TW+1)'(TAG_DEPTH));
  assign tag_empty_s = (tag_cnt_r == '0);
  assign res_pop_s   = EX_ALU_VLD & ~tag_empty_s;

  // In-order tag FIFO recording the channel of each issued operation
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int t = 0; t < TAG_DEPTH; t++) tag_mem_r[t] <= '0;
      tag_wr_r  <= '0;
      tag_rd_r  <= '0;
      tag_cnt_r <= '0;
    end else begin
      if (act_s) begin
        tag_mem_r[tag_wr_r] <= grant_s;
        tag_wr_r            <= tag_wr_r + TW'(1);
      end
      if (res_pop_s) tag_rd_r <= tag_rd_r + TW'(1);
      case ({act_s, res_pop_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + (TW+1)'(1);
        2'b01:   tag_cnt_r <= tag_cnt_r - (TW+1)'(1);
        default: tag_cnt_r <= tag_cnt_r;
      endcase
    end
  end

  // Tagged result register and sticky error for untagged results
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_vld_r  <= 1'b0;
      res_ch_r   <= '0;
      res_data_r <= '0;
      err_r      <= 1'b0;
    end else begin
      res_vld_r <= res_pop_s;
      err_r     <= err_r | (EX_ALU_VLD & tag_empty_s);
      if (res_pop_s) begin
        res_ch_r   <= tag_mem_r[tag_rd_r];
        res_data_r <= EX_ALU;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] issue_cnt_r, stall_cnt_r;

  // Saturating issue and stall counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      issue_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (act_s && issue_cnt_r != 32'hFFFF_FFFF) issue_cnt_r <= issue_cnt_r + 32'd1;
      if (found_s && !act_s && stall_cnt_r != 32'hFFFF_FFFF) stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign ISSUE_CNT = issue_cnt_r;
  assign STALL_CNT = stall_cnt_r;
`endif

  assign IN_RDY   = in_rdy_s;
  assign ACT      = act_s;
  assign OP       = out_req_s.op;
  assign MOVI     = out_req_s.movi;
  assign REG_A    = out_req_s.reg_a;
  assign REG_B    = out_req_s.reg_b;
  assign IMM      = out_req_s.imm;
  assign MEM      = out_req_s.mem;
  assign RES_VLD  = res_vld_r;
  assign RES_CH   = res_ch_r;
  assign RES_DATA = res_data_r;
  assign ERR      = err_r;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: round-robin order, FIFO full, tag tracking, tag-full stall, error and reset.
module tb_alu_req_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  IN_ACT = 4'd0;
  logic [3:0]  IN_RDY;
  logic [15:0] IN_OP = 16'd0;
  logic [7:0]  IN_MOVI = 8'd0;
  logic [31:0] IN_REG_A = 32'd0, IN_REG_B = 32'd0, IN_IMM = 32'd0, IN_MEM = 32'd0;
  logic        ALU_RDY = 1'b0;
  logic        ACT;
  logic [3:0]  OP;
  logic [1:0]  MOVI;
  logic [7:0]  REG_A, REG_B, IMM, MEM;
  logic [7:0]  EX_ALU = 8'd0;
  logic        EX_ALU_VLD = 1'b0;
  logic        RES_VLD;
  logic [1:0]  RES_CH;
  logic [7:0]  RES_DATA;
  logic        ERR;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] ISSUE_CNT, STALL_CNT;
`endif

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  alu_req_arbiter dut (
    .CLK(CLK), .RST(RST), .IN_ACT(IN_ACT), .IN_RDY(IN_RDY), .IN_OP(IN_OP), .IN_MOVI(IN_MOVI),
    .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B), .IN_IMM(IN_IMM), .IN_MEM(IN_MEM),
    .ALU_RDY(ALU_RDY), .ACT(ACT), .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B),
    .IMM(IMM), .MEM(MEM), .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD), .RES_VLD(RES_VLD),
    .RES_CH(RES_CH), .RES_DATA(RES_DATA), .ERR(ERR)
`ifdef ALU_ARB_STATS_EN
    , .ISSUE_CNT(ISSUE_CNT), .STALL_CNT(STALL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input int c, input logic [3:0] op, input logic [7:0] a);
    IN_ACT[c]          = 1'b1;
    IN_OP[4*c +: 4]    = op;
    IN_MOVI[2*c +: 2]  = 2'(c);
    IN_REG_A[8*c +: 8] = a;
    IN_REG_B[8*c +: 8] = ~a;
    IN_IMM[8*c +: 8]   = a + 8'd1;
    IN_MEM[8*c +: 8]   = a ^ 8'h55;
  endtask

  // Return n results (base, base+step, ...) and check channel tags against exp_q
  task automatic drain(input int n, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d          = base + 8'(i) * step;
      EX_ALU_VLD = 1'b1;
      EX_ALU     = d;
      tick();
      chk("res_vld", 32'(RES_VLD), 32'd1);
      chk("res_ch", 32'(RES_CH), 32'(exp_q.pop_front()));
      chk("res_data", 32'(RES_DATA), 32'(d));
    end
    EX_ALU_VLD = 1'b0;
    tick();
    chk("res_idle", 32'(RES_VLD), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, k;
    // Reset state, with requests driven during reset
    IN_ACT = 4'hF;
    #12;
    chk("rst_in_rdy", 32'(IN_RDY), 32'd0);
    chk("rst_act", 32'(ACT), 32'd0);
    chk("rst_res_vld", 32'(RES_VLD), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_res_ch", 32'(RES_CH), 32'd0);
    chk("rst_res_data", 32'(RES_DATA), 32'd0);
    chk("rst_op", 32'(OP), 32'd0);
    IN_ACT = 4'h0;
    RST = 1'b1;
    tick();
    chk("post_rst_act", 32'(ACT), 32'd0);

    // Two ops per channel, then round-robin issue 0,1,2,3,0,1,2,3
    for (int i = 0; i < 4; i++) put(i, 4'(4*i), 8'(16*i));
    #1;
    chk("in_rdy_all", 32'(IN_RDY), 32'hF);
    tick();
    for (int i = 0; i < 4; i++) put(i, 4'(4*i+1), 8'(16*i+1));
    tick();
    IN_ACT  = 4'h0;
    ALU_RDY = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      c = i % 4;
      k = i / 4;
      chk("rr_act", 32'(ACT), 32'd1);
      chk("rr_op", 32'(OP), 32'(4*c+k));
      chk("rr_reg_a", 32'(REG_A), 32'(16*c+k));
      chk("rr_movi", 32'(MOVI), 32'(c));
      chk("rr_mem", 32'(MEM), 32'(8'(16*c+k) ^ 8'h55));
      exp_q.push_back(c);
      tick();
    end
    chk("rr_idle", 32'(ACT), 32'd0);
    chk("op_hold", 32'(OP), 32'd13);
    chk("imm_hold", 32'(IMM), 32'h32);

    // Tag FIFO full: pending request blocked until one result drains a tag
    put(1, 4'h9, 8'h99);
    tick();
    IN_ACT = 4'h0;
    #1;
    chk("tagfull_block0", 32'(ACT), 32'd0);
    tick();
    chk("tagfull_block1", 32'(ACT), 32'd0);
    EX_ALU_VLD = 1'b1;
    EX_ALU     = 8'hA0;
    #1;
    chk("tagfull_block2", 32'(ACT), 32'd0);
    tick();
    EX_ALU_VLD = 1'b0;
    #1;
    chk("tagfull_res_vld", 32'(RES_VLD), 32'd1);
    chk("tagfull_res_ch", 32'(RES_CH), 32'(exp_q.pop_front()));
    chk("tagfull_res_data", 32'(RES_DATA), 32'hA0);
    chk("tagfull_act", 32'(ACT), 32'd1);
    chk("tagfull_op", 32'(OP), 32'h9);
    exp_q.push_back(1);
    tick();
    chk("tagfull_empty", 32'(ACT), 32'd0);
    ALU_RDY = 1'b0;
    drain(8, 8'hB0, 8'h01);

    // Fill channel 1, drop a fifth write, then exactly four issue in order
    for (int i = 0; i < 4; i++) begin
      put(1, 4'(i+4), 8'(8'h40 + 8'(i)));
      #1;
      chk("fill_in_rdy", 32'(IN_RDY[1]), 32'd1);
      tick();
    end
    put(1, 4'hF, 8'hFF);
    #1;
    chk("full_in_rdy", 32'(IN_RDY), 32'hD);
    tick();
    IN_ACT  = 4'h0;
    ALU_RDY = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("full_act", 32'(ACT), 32'd1);
      chk("full_op", 32'(OP), 32'(i+4));
      chk("full_reg_a", 32'(REG_A), 32'(8'h40 + 8'(i)));
      exp_q.push_back(1);
      tick();
    end
    chk("full_dropped", 32'(ACT), 32'd0);
    ALU_RDY = 1'b0;
    drain(4, 8'hC0, 8'h01);

    // Issue ch2, ch0, ch2 then return 0x11, 0x22, 0x33
    put(0, 4'h1, 8'h01);
    put(2, 4'h2, 8'h02);
    tick();
    IN_ACT = 4'h0;
    put(2, 4'h3, 8'h03);
    tick();
    IN_ACT  = 4'h0;
    ALU_RDY = 1'b1;
    #1;
    chk("tag_op0", 32'(OP), 32'h2);
    exp_q.push_back(2);
    tick();
    chk("tag_op1", 32'(OP), 32'h1);
    exp_q.push_back(0);
    tick();
    chk("tag_op2", 32'(OP), 32'h3);
    exp_q.push_back(2);
    tick();
    ALU_RDY = 1'b0;
    drain(3, 8'h11, 8'h11);

    // Result with no outstanding tag sets a sticky error
    chk("err_pre", 32'(ERR), 32'd0);
    EX_ALU_VLD = 1'b1;
    EX_ALU     = 8'h5A;
    tick();
    EX_ALU_VLD = 1'b0;
    chk("err_set", 32'(ERR), 32'd1);
    chk("err_no_res", 32'(RES_VLD), 32'd0);
    tick();
    tick();
    chk("err_sticky", 32'(ERR), 32'd1);

    // Reset with two outstanding and three queued
    put(3, 4'h6, 8'h61);
    put(1, 4'h7, 8'h62);
    tick();
    IN_ACT  = 4'h0;
    ALU_RDY = 1'b1;
    #1;
    chk("pre_rst_op0", 32'(OP), 32'h6);
    tick();
    chk("pre_rst_op1", 32'(OP), 32'h7);
    tick();
    ALU_RDY = 1'b0;
    put(1, 4'h8, 8'h63);
    put(2, 4'h8, 8'h64);
    put(3, 4'h8, 8'h65);
    tick();
    IN_ACT     = 4'h0;
    RST        = 1'b0;
    ALU_RDY    = 1'b1;
    EX_ALU_VLD = 1'b1;
    #1;
    chk("mid_rst_act", 32'(ACT), 32'd0);
    chk("mid_rst_in_rdy", 32'(IN_RDY), 32'd0);
    chk("mid_rst_err", 32'(ERR), 32'd0);
    chk("mid_rst_res_ch", 32'(RES_CH), 32'd0);
    chk("mid_rst_res_data", 32'(RES_DATA), 32'd0);
    chk("mid_rst_op", 32'(OP), 32'd0);
    chk("mid_rst_reg_a", 32'(REG_A), 32'd0);
    tick();
    EX_ALU_VLD = 1'b0;
    RST        = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", 32'(ACT), 32'd0);
    chk("post_rst_res", 32'(RES_VLD), 32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("stats_issue_rst", ISSUE_CNT, 32'd0);
    chk("stats_stall_rst", STALL_CNT, 32'd0);
`endif
    put(1, 4'hA, 8'h71);
    put(3, 4'hB, 8'h73);
    tick();
    IN_ACT = 4'h0;
    #1;
    chk("rr_after_rst0", 32'(OP), 32'hA);
    exp_q.push_back(1);
    tick();
    chk("rr_after_rst1", 32'(OP), 32'hB);
    exp_q.push_back(3);
    tick();
    ALU_RDY = 1'b0;
    drain(2, 8'hD0, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
